router_fsm: RTL and testbench
=============================

# router_fsm

Packet-level control FSM of the 1x4 router, sitting directly upstream of the input register stage: it watches the incoming byte stream (`pkt_valid`, header address bits) and the destination FIFO status, and drives the per-state strobes that tell the register stage when to capture the header, load payload, hold on a full FIFO, load parity and check it. It also drives `busy` back to the packet source and `write_enb_reg` to the write synchronizer.

## Interface
- `NUM_PORTS`, default 4: number of destination FIFOs; address width is `ADDR_W = $clog2(NUM_PORTS)`, which is 2 at the default.
- `clk`, input, 1: clock; all state changes occur on the rising edge.
- `resetn`, input, 1: reset, synchronous, active-low.
- `pkt_valid`, input, 1: the source is presenting a valid packet byte.
- `data_in`, input, ADDR_W: low header bits, sampled only in DECODE_ADDRESS to select the destination.
- `fifo_full`, input, 1: full flag of the currently selected FIFO, supplied by the synchronizer.
- `fifo_empty`, input, NUM_PORTS: empty flag of each FIFO.
- `soft_reset`, input, NUM_PORTS: per-FIFO read-timeout reset, supplied by the synchronizer.
- `parity_done`, input, 1: from the register stage.
- `low_packet_valid`, input, 1: from the register stage.
- `detect_add`, output, 1: state is DECODE_ADDRESS.
- `lfd_state`, output, 1: state is LOAD_FIRST_DATA.
- `ld_state`, output, 1: state is LOAD_DATA.
- `full_state`, output, 1: state is FIFO_FULL_STATE.
- `laf_state`, output, 1: state is LOAD_AFTER_FULL.
- `rst_int_reg`, output, 1: state is CHECK_PARITY_ERROR.
- `write_enb_reg`, output, 1: FIFO write enable.
- `busy`, output, 1: the source must hold its current byte.

## Operation
- There are 8 states: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE).
- `addr_q` (ADDR_W bits) latches `data_in` in DA when `pkt_valid=1`. The state's routing decisions use `data_in` directly in the same cycle.
- Transitions:
  - DA: if `pkt_valid & fifo_empty[data_in]`, go to LFD; if `pkt_valid & ~fifo_empty[data_in]`, go to WTE; otherwise stay in DA.
  - WTE: if `fifo_empty[addr_q]`, go to LFD; otherwise stay.
  - LFD: go to LD unconditionally.
  - LD: if `fifo_full`, go to FFS; else if `~pkt_valid`, go to LP; otherwise stay. `fifo_full` has priority.
  - FFS: if `~fifo_full`, go to LAF; otherwise stay.
  - LAF: if `parity_done`, go to DA; else if `low_packet_valid`, go to LP; otherwise go to LD.
  - LP: go to CPE unconditionally.
  - CPE: if `fifo_full`, go to FFS; otherwise go to DA.
- `soft_reset[addr_q]=1` in any state other than DA forces the next state to DA and overrides every transition above. `soft_reset` bits for other ports are ignored.
- Outputs are Moore outputs, decoded only from the registered state:
  - Each one-hot strobe follows its state as listed in the interface.
  - `write_enb_reg` = LD | LAF | LP.
  - `busy` = 1 in LFD, WTE, FFS, LAF, LP and CPE; 0 in DA and LD.

## Timing
- Reset (`resetn=0` at a clock edge) puts the state in DA and clears `addr_q` to 0.
- Output values during reset: `detect_add=1`; `lfd_state`, `ld_state`, `full_state`, `laf_state`, `rst_int_reg`, `write_enb_reg` and `busy` all 0.
- Reset applied mid-packet, in any state, returns to DA at that edge.
- Latency: all outputs change exactly one cycle after the input condition that causes the transition. There is no combinational path from any input to any output.
- Header handshake: the header byte is on the bus in DA, the FSM is in LFD on the next cycle, and the first payload byte is accepted in LD the cycle after that. `busy=1` in LFD stalls the source for exactly one cycle.
- Packet end: `pkt_valid` falling while in LD gives LP on the next cycle, then CPE, then DA, for 3 cycles in total.
- Simultaneous `fifo_full` and `~pkt_valid` in LD: FFS wins. Parity is recovered through LAF, with `low_packet_valid=1` leading to LP.
- `soft_reset` in WTE abandons the wait; the source must resend the packet.

## Test plan
- **Reset:** hold `resetn=0` for 2 cycles with random inputs → `detect_add=1`, all other outputs 0; DA is held after release while `pkt_valid=0`.
- **Normal packet:** port 2 with `fifo_empty=4'b1111`, header then 3 payload bytes, `pkt_valid` dropping on the parity byte → state sequence DA, LFD, LD, LD, LD, LP, CPE, DA; `write_enb_reg` high for 4 cycles (3 LD + LP); `busy` high in LFD, LP and CPE only.
- **Busy destination:** header to port 1 with `fifo_empty=4'b1101` → WTE with `busy=1`; assert `fifo_empty[1]` at cycle 5 → LFD at cycle 6.
- **FIFO full:** assert `fifo_full` in LD for 3 cycles → FFS with `busy=1` and `write_enb_reg=0` throughout; then LAF; with `parity_done=0` and `low_packet_valid=0` → back to LD.
- **Full at packet end:** `fifo_full=1` and `pkt_valid=0` in the same LD cycle → FFS; on release, LAF with `low_packet_valid=1` → LP, then CPE, then DA.
- **Soft reset:** `addr_q=3`, in FFS, pulse `soft_reset=4'b0001` → no effect; pulse `soft_reset=4'b1000` → DA on the next cycle with `detect_add=1`.

Source files
------------

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet control FSM of the 1x4 router, driving register-stage strobes, busy and write enable
module router_fsm #(
  parameter int NUM_PORTS = 4,
  localparam int ADDR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    WAIT_TILL_EMPTY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid)
        addr_q <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        // Routing uses the live header bits; addr_q only becomes valid next cycle
        if (pkt_valid && fifo_empty[data_in])
          next_state = LOAD_FIRST_DATA;
        else if (pkt_valid)
          next_state = WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[addr_q])
          next_state = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA:
        next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)
          next_state = FIFO_FULL_STATE;
        else if (!pkt_valid)
          next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          next_state = DECODE_ADDRESS;
        else if (low_packet_valid)
          next_state = LOAD_PARITY;
        else
          next_state = LOAD_DATA;
      end
      LOAD_PARITY:
        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full)
          next_state = FIFO_FULL_STATE;
        else
          next_state = DECODE_ADDRESS;
      end
      default:
        next_state = DECODE_ADDRESS;
    endcase

    // A read timeout on the selected port abandons the packet from any active state
    if (state != DECODE_ADDRESS && soft_reset[addr_q])
      next_state = DECODE_ADDRESS;
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_reg = ld_state || laf_state || (state == LOAD_PARITY);
  assign busy          = !(detect_add || ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - scoreboard bench for router_fsm using directed state-sequence vectors
module tb_router_fsm;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [3:0] fifo_empty;
  logic [3:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, full_state;
  logic       laf_state, rst_int_reg, write_enb_reg, busy;

  router_fsm #(.NUM_PORTS(4)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0010;
  localparam logic [7:0] E_WTE = 8'b0000_0001;
  localparam logic [7:0] E_FFS = 8'b0001_0001;
  localparam logic [7:0] E_LAF = 8'b0000_1011;
  localparam logic [7:0] E_LP  = 8'b0000_0011;
  localparam logic [7:0] E_CPE = 8'b0000_0101;

  typedef struct {
    logic [7:0] exp;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   step_id = 0;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Inputs are applied at the falling edge; the expected post-edge outputs are queued.
  task automatic step(input logic rn, input logic pv, input logic [1:0] din,
                      input logic ff, input logic [3:0] fe, input logic [3:0] sr,
                      input logic pd, input logic lpv, input logic [7:0] exp);
    exp_t e;
    @(negedge clk);
    resetn = rn; pkt_valid = pv; data_in = din; fifo_full = ff;
    fifo_empty = fe; soft_reset = sr; parity_done = pd; low_packet_valid = lpv;
    e.exp = exp;
    e.id  = step_id;
    exp_q.push_back(e);
    step_id++;
  endtask

  always begin
    exp_t e;
    logic [7:0] act;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {detect_add, lfd_state, ld_state, full_state,
             laf_state, rst_int_reg, write_enb_reg, busy};
      checks++;
      if (act === e.exp)
        passed++;
      else
        $display("FAIL step %0d outputs: got %b expected %b", e.id, act, e.exp);
    end
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 4'b1111; soft_reset = 4'b0000; parity_done = 1'b0; low_packet_valid = 1'b0;

    // Reset with random inputs, then idle in DA
    repeat (2) step(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
                    4'($urandom), 1'($urandom), 1'($urandom), E_DA);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);
    step(1, 0, 2'd2, 0, 4'b1111, 4'b0000, 0, 0, E_DA);

    // Normal packet to port 2
    step(1, 1, 2'd2, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LP);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_CPE);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);

    // Busy destination: wait uses the latched address, not live data_in
    step(1, 1, 2'd1, 0, 4'b1101, 4'b0000, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 4'b1101, 4'b0000, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 4'b1101, 4'b0000, 0, 0, E_WTE);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LP);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_CPE);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);

    // FIFO full mid-packet, recovery through LAF back to LD
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LAF);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LP);
    // CPE with full FIFO goes back to FFS, then LAF with parity_done ends the packet
    step(1, 0, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_CPE);
    step(1, 0, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LAF);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 1, 0, E_DA);

    // Full at packet end: FFS wins, parity recovered via low_packet_valid
    step(1, 1, 2'd1, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 0, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LAF);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 1, E_LP);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_CPE);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);

    // Soft reset on port 3 while in FFS; other ports' bits ignored
    step(1, 1, 2'd3, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b0000, 0, 0, E_FFS);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b0001, 0, 0, E_FFS);
    step(1, 1, 2'd0, 1, 4'b1111, 4'b1000, 0, 0, E_DA);
    // Soft reset has no effect in DA
    step(1, 0, 2'd0, 0, 4'b1111, 4'b1000, 0, 0, E_DA);

    // Soft reset abandons WTE
    step(1, 1, 2'd1, 0, 4'b1101, 4'b0000, 0, 0, E_WTE);
    step(1, 1, 2'd1, 0, 4'b1101, 4'b0010, 0, 0, E_DA);

    // Reset mid-packet
    step(1, 1, 2'd2, 0, 4'b1111, 4'b0000, 0, 0, E_LFD);
    step(1, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_LD);
    step(0, 1, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);
    step(1, 0, 2'd0, 0, 4'b1111, 4'b0000, 0, 0, E_DA);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
